// File: rtl/ledger_pkg.sv
// Shared types and arithmetic for the cancelled-order ledger: default widths,
// the queued cancellation entry and the saturating accumulate.
package ledger_pkg;

    localparam int CLIENT_W = 5;
    localparam int AMT_W    = 16;

    // One queued cancellation: which client and how much was cancelled.
    typedef struct packed {
        logic [CLIENT_W-1:0] client;
        logic [AMT_W-1:0]    amount;
    } cxl_entry_t;

    // Saturating add. Bit AMT_W of the result is the saturation flag and
    // bits [AMT_W-1:0] hold the value to store (all-ones when saturated).
    function automatic logic [AMT_W:0] sat_add(
        input logic [AMT_W-1:0] total,
        input logic [AMT_W-1:0] amount
    );
        logic [AMT_W:0] sum;
        sum = {1'b0, total} + {1'b0, amount};
        if (sum[AMT_W]) begin
            sat_add = {1'b1, {AMT_W{1'b1}}};
        end else begin
            sat_add = {1'b0, sum[AMT_W-1:0]};
        end
    endfunction

endpackage

// File: rtl/cancel_fifo.sv
// Small synchronous FIFO of cancellation entries. Push and pop are ignored
// when they would overflow or underflow, so the level can never go out of
// range even if a caller misbehaves.
module cancel_fifo
    import ledger_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  cxl_entry_t       push_data,
    input  logic             pop,
    output cxl_entry_t       head,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_DEPTH = LVL_W'(DEPTH);

    cxl_entry_t       mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (level_r == LVL_DEPTH);
    assign empty     = (level_r == '0);
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign head      = mem_r[rd_ptr_r];
    assign level     = level_r;

    // Storage array: written at the tail on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
            end
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; the level
    // counter is what tells full apart from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   level_r <= level_r + LVL_ONE;
                2'b01:   level_r <= level_r - LVL_ONE;
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/cancel_ledger.sv
// Per-client cancelled-order ledger. Cancellation events are queued in a
// small FIFO and drained one per cycle into a saturating per-client total.
// A settle request zeroes one client and takes priority over the drain for
// that cycle, so a queued event for the same client lands after the clear.
// The read register is write-through: it shows the total as it will be
// after the current edge, including any drain or settle on that edge.
module cancel_ledger #(
    parameter  int N_CLIENTS  = 32,
    parameter  int CLIENT_W   = ledger_pkg::CLIENT_W,
    parameter  int AMT_W      = ledger_pkg::AMT_W,
    parameter  int FIFO_DEPTH = 4,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                HRESETn,
    input  logic                cxl_valid,
    output logic                cxl_ready,
    input  logic [CLIENT_W-1:0] cxl_client,
    input  logic [AMT_W-1:0]    cxl_amount,
    input  logic                clr_valid,
    input  logic [CLIENT_W-1:0] clr_client,
    input  logic [CLIENT_W-1:0] rd_client,
    output logic [AMT_W-1:0]    cancelled_orders,
    output logic                sat_pulse,
    output logic [LVL_W-1:0]    fifo_level
);

    import ledger_pkg::*;

    cxl_entry_t       push_entry_s;
    cxl_entry_t       head_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             push_s;
    logic             drain_s;
    logic [AMT_W:0]   sum_s;
    logic             sat_next_s;
    logic [AMT_W-1:0] ledger_r    [N_CLIENTS];
    logic [AMT_W-1:0] ledger_next_s [N_CLIENTS];

    // Ready depends only on the registered level and reset, never on valid.
    assign cxl_ready    = !fifo_full_s && HRESETn;
    assign push_s       = cxl_valid && cxl_ready;
    assign drain_s      = !fifo_empty_s && !clr_valid;
    assign push_entry_s = {cxl_client, cxl_amount};

    cancel_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (HRESETn),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (drain_s),
        .head      (head_s),
        .level     (fifo_level),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Next ledger contents: settle wins over drain; drain accumulates the
    // FIFO head into its client with saturation.
    always_comb begin
        for (int i = 0; i < N_CLIENTS; i++) begin
            ledger_next_s[i] = ledger_r[i];
        end
        sat_next_s = 1'b0;
        sum_s      = sat_add(ledger_r[head_s.client], head_s.amount);
        if (clr_valid) begin
            ledger_next_s[clr_client] = '0;
        end else if (drain_s) begin
            ledger_next_s[head_s.client] = sum_s[AMT_W-1:0];
            sat_next_s                   = sum_s[AMT_W];
        end else begin
            sat_next_s = 1'b0;
        end
    end

    // Ledger flop array.
    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < N_CLIENTS; i++) begin
                ledger_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CLIENTS; i++) begin
                ledger_r[i] <= ledger_next_s[i];
            end
        end
    end

    // Registered outputs: write-through read of the queried client and the
    // one-cycle saturation indication.
    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            cancelled_orders <= '0;
            sat_pulse        <= 1'b0;
        end else begin
            cancelled_orders <= ledger_next_s[rd_client];
            sat_pulse        <= sat_next_s;
        end
    end

endmodule

// File: tb/tb_cancel_ledger.sv
// Directed bench for cancel_ledger with hand-computed expected values.
module tb_cancel_ledger;

    logic        clk;
    logic        HRESETn;
    logic        cxl_valid;
    logic        cxl_ready;
    logic [4:0]  cxl_client;
    logic [15:0] cxl_amount;
    logic        clr_valid;
    logic [4:0]  clr_client;
    logic [4:0]  rd_client;
    logic [15:0] cancelled_orders;
    logic        sat_pulse;
    logic [2:0]  fifo_level;

    int n_tests = 0;
    int n_fail  = 0;

    cancel_ledger dut (
        .clk              (clk),
        .HRESETn          (HRESETn),
        .cxl_valid        (cxl_valid),
        .cxl_ready        (cxl_ready),
        .cxl_client       (cxl_client),
        .cxl_amount       (cxl_amount),
        .clr_valid        (clr_valid),
        .clr_client       (clr_client),
        .rd_client        (rd_client),
        .cancelled_orders (cancelled_orders),
        .sat_pulse        (sat_pulse),
        .fifo_level       (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one event for exactly one edge.
    task automatic offer(input logic [4:0] c, input logic [15:0] a);
        cxl_valid  = 1'b1;
        cxl_client = c;
        cxl_amount = a;
        step();
        cxl_valid  = 1'b0;
    endtask

    initial begin
        HRESETn    = 1'b0;
        cxl_valid  = 1'b0;
        cxl_client = 5'd0;
        cxl_amount = 16'd0;
        clr_valid  = 1'b0;
        clr_client = 5'd0;
        rd_client  = 5'd3;

        // Reset state.
        step();
        step();
        check_eq("rst_orders", {16'd0, cancelled_orders}, 32'd0);
        check_eq("rst_sat",    {31'd0, sat_pulse},        32'd0);
        check_eq("rst_level",  {29'd0, fifo_level},       32'd0);
        check_eq("rst_ready",  {31'd0, cxl_ready},        32'd0);
        HRESETn = 1'b1;
        #1;
        check_eq("ready_after_release", {31'd0, cxl_ready}, 32'd1);

        // Single event client 3 amount 100.
        offer(5'd3, 16'd100);
        check_eq("t1_level_after_accept", {29'd0, fifo_level}, 32'd1);
        check_eq("t1_orders_before_drain", {16'd0, cancelled_orders}, 32'd0);
        step();
        check_eq("t1_orders", {16'd0, cancelled_orders}, 32'd100);
        check_eq("t1_level_drained", {29'd0, fifo_level}, 32'd0);

        // Fill the FIFO while settle stalls the drain.
        clr_valid  = 1'b1;
        clr_client = 5'd0;
        offer(5'd10, 16'd1);
        offer(5'd10, 16'd2);
        offer(5'd11, 16'd3);
        check_eq("t2_level3", {29'd0, fifo_level}, 32'd3);
        check_eq("t2_ready3", {31'd0, cxl_ready},  32'd1);
        offer(5'd10, 16'd4);
        check_eq("t2_level4", {29'd0, fifo_level}, 32'd4);
        check_eq("t2_ready_full", {31'd0, cxl_ready}, 32'd0);
        offer(5'd12, 16'd99);
        check_eq("t2_level_no_overflow", {29'd0, fifo_level}, 32'd4);
        clr_valid = 1'b0;
        rd_client = 5'd10;
        step();
        check_eq("t2_drain1", {16'd0, cancelled_orders}, 32'd1);
        check_eq("t2_level_d1", {29'd0, fifo_level}, 32'd3);
        step();
        check_eq("t2_drain2", {16'd0, cancelled_orders}, 32'd3);
        step();
        check_eq("t2_drain3", {16'd0, cancelled_orders}, 32'd3);
        step();
        check_eq("t2_drain4", {16'd0, cancelled_orders}, 32'd7);
        check_eq("t2_level_empty", {29'd0, fifo_level}, 32'd0);
        rd_client = 5'd11;
        step();
        check_eq("t2_client11", {16'd0, cancelled_orders}, 32'd3);
        rd_client = 5'd12;
        step();
        check_eq("t2_client12_dropped", {16'd0, cancelled_orders}, 32'd0);

        // Saturation on client 7.
        rd_client = 5'd7;
        offer(5'd7, 16'hFFF0);
        step();
        check_eq("t3_base", {16'd0, cancelled_orders}, 32'h0000FFF0);
        check_eq("t3_no_sat_base", {31'd0, sat_pulse}, 32'd0);
        offer(5'd7, 16'h0020);
        step();
        check_eq("t3_saturated", {16'd0, cancelled_orders}, 32'h0000FFFF);
        check_eq("t3_sat_pulse", {31'd0, sat_pulse}, 32'd1);
        step();
        check_eq("t3_sat_one_cycle", {31'd0, sat_pulse}, 32'd0);
        offer(5'd7, 16'h0000);
        step();
        check_eq("t3_zero_add", {16'd0, cancelled_orders}, 32'h0000FFFF);
        check_eq("t3_zero_no_pulse", {31'd0, sat_pulse}, 32'd0);
        check_eq("t3_zero_drained", {29'd0, fifo_level}, 32'd0);

        // Settle racing a queued event for the same client.
        rd_client = 5'd5;
        offer(5'd5, 16'd50);
        step();
        check_eq("t4_base", {16'd0, cancelled_orders}, 32'd50);
        offer(5'd5, 16'd10);
        clr_valid  = 1'b1;
        clr_client = 5'd5;
        step();
        clr_valid = 1'b0;
        check_eq("t4_cleared", {16'd0, cancelled_orders}, 32'd0);
        check_eq("t4_head_held", {29'd0, fifo_level}, 32'd1);
        step();
        check_eq("t4_after_clear", {16'd0, cancelled_orders}, 32'd10);
        check_eq("t4_level", {29'd0, fifo_level}, 32'd0);

        // Read-client switch on the same edge as a drain.
        rd_client = 5'd1;
        offer(5'd2, 16'd30);
        check_eq("t5_client1", {16'd0, cancelled_orders}, 32'd0);
        rd_client = 5'd2;
        step();
        check_eq("t5_write_through", {16'd0, cancelled_orders}, 32'd30);

        // Reset mid-stream with three queued events.
        rd_client  = 5'd3;
        clr_valid  = 1'b1;
        clr_client = 5'd0;
        offer(5'd3, 16'd5);
        offer(5'd4, 16'd6);
        offer(5'd5, 16'd7);
        check_eq("t6_level3", {29'd0, fifo_level}, 32'd3);
        check_eq("t6_pre_reset", {16'd0, cancelled_orders}, 32'd100);
        #2;
        HRESETn = 1'b0;
        #1;
        check_eq("t6_orders_async", {16'd0, cancelled_orders}, 32'd0);
        check_eq("t6_level_async",  {29'd0, fifo_level},       32'd0);
        check_eq("t6_ready_async",  {31'd0, cxl_ready},        32'd0);
        clr_valid = 1'b0;
        #3;
        HRESETn = 1'b1;
        #1;
        check_eq("t6_ready_release", {31'd0, cxl_ready}, 32'd1);
        step();
        check_eq("t6_client3_zero", {16'd0, cancelled_orders}, 32'd0);
        check_eq("t6_no_stale", {29'd0, fifo_level}, 32'd0);
        rd_client = 5'd4;
        step();
        check_eq("t6_client4_zero", {16'd0, cancelled_orders}, 32'd0);
        rd_client = 5'd7;
        step();
        check_eq("t6_client7_zero", {16'd0, cancelled_orders}, 32'd0);
        rd_client = 5'd10;
        step();
        check_eq("t6_client10_zero", {16'd0, cancelled_orders}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cancel_ledger.md
# cancel_ledger

Per-client cancelled-order ledger feeding the `cancelled_orders` input of `upstream_processor_top`. It accepts cancellation events from the downstream side through a valid/ready handshake and buffers them in a 4-deep FIFO. It accumulates them per client with saturation and presents the cancelled total for the client the risk checker is currently evaluating. A settle (clear) port zeroes a client's total once its orders are reconciled.

## Interface
- `N_CLIENTS`, 32: number of ledger entries; must equal 2**`CLIENT_W`.
- `CLIENT_W`, 5: client index width.
- `AMT_W`, 16: amount and total width.
- `FIFO_DEPTH`, 4: cancel FIFO depth; must be a power of two.
- `clk` in 1: single clock, rising edge.
- `HRESETn` in 1: reset, asynchronous assert, active-low.
- `cxl_valid` in 1: cancellation event present.
- `cxl_ready` out 1: FIFO can accept an event.
- `cxl_client` in `CLIENT_W`: client of the cancellation.
- `cxl_amount` in `AMT_W`: cancelled quantity, unsigned.
- `clr_valid` in 1: settle request, single-cycle pulse.
- `clr_client` in `CLIENT_W`: client to zero.
- `rd_client` in `CLIENT_W`: client the risk check is querying; driven from the same `client_id` as the risk stage.
- `cancelled_orders` out `AMT_W`: registered ledger total for `rd_client`.
- `sat_pulse` out 1: one-cycle pulse when an update saturated.
- `fifo_level` out `$clog2(FIFO_DEPTH)+1`: number of queued events.

## Operation
- Reset (HRESETn low): all ledger entries 0, FIFO empty, `cancelled_orders`=0, `sat_pulse`=0, `fifo_level`=0, `cxl_ready`=0.
- `cxl_ready` = (`fifo_level` < `FIFO_DEPTH`) && HRESETn. It is combinational from registered level only and does not depend on `cxl_valid`.
- Enqueue occurs on an edge where `cxl_valid` && `cxl_ready`. Events are pushed in arrival order.
- Drain happens on each edge where the FIFO is non-empty and `clr_valid`=0:
  - pop the head entry;
  - ledger[head.client] <= sat(ledger[head.client] + head.amount).
- Saturation arithmetic:
  - the sum is computed at `AMT_W`+1 bits;
  - if bit `AMT_W` is set, store all-ones and assert `sat_pulse` on the next cycle;
  - otherwise store the sum and leave `sat_pulse` low.
- An event with amount 0 drains normally, leaves the entry unchanged and does not pulse.
- Settle: on an edge with `clr_valid`=1, ledger[`clr_client`] <= 0. The drain is stalled that cycle and the FIFO head is held. A queued event for the same client is therefore applied after the clear.
- Simultaneous enqueue and drain leaves `fifo_level` unchanged. Enqueue while full cannot occur because `cxl_ready` is 0.
- FIFO pointers wrap modulo `FIFO_DEPTH`. `fifo_level` separates full from empty.
- Read path: `cancelled_orders` <= ledger_next[`rd_client`]. This is a write-through value, so it includes any drain or clear committing on the same edge.
- Asserting HRESETn low mid-operation discards queued events and zeroes all totals immediately.

## Timing
- Event accepted at edge k is drained at edge k+1 at the earliest, if the FIFO was empty and `clr_valid` is low at k+1.
- The ledger total is visible on `cancelled_orders` after edge k+1, provided `rd_client` equals the event's client at k+1.
- With a backlog, each queued event waits one additional cycle per entry ahead of it. Each settle cycle adds one more stall cycle.
- A `rd_client` change is reflected on `cancelled_orders` after the next edge, so read latency is 1 cycle.
- `sat_pulse` is high for exactly the cycle after the saturating drain edge.
- Sustained throughput is 1 event per cycle with zero settle traffic.
- On reset deassertion, `cxl_ready` rises combinationally. The first accept is possible at the first edge after deassertion.

## Structure
- A shared package `ledger_pkg` holds:
  - `CLIENT_W` and `AMT_W` defaults;
  - `typedef struct packed { logic [CLIENT_W-1:0] client; logic [AMT_W-1:0] amount; } cxl_entry_t`;
  - the saturating-add function.
- Sub-module `cancel_fifo` is a synchronous FIFO of `cxl_entry_t` with push/pop/level and asynchronous active-low reset.
- Top level `cancel_ledger` contains:
  - the ledger flop array (`N_CLIENTS` x `AMT_W`), async-reset to 0;
  - drain/clear arbitration;
  - the write-through read register.

## Test plan
- Reset, then enqueue client 3 amount 100 at edge 1 with `rd_client`=3 -> `cancelled_orders`=100 after edge 2; `fifo_level` returns to 0.
- Four back-to-back events while `clr_valid` is held high, then a fifth offered -> `cxl_ready`=0 after the fourth accept and level=4. When `clr_valid` drops, all four drain in order with no loss.
- Client 7 at 0xFFF0, then add 0x0020 -> entry=0xFFFF and `sat_pulse` high for exactly one cycle. Adding 0 afterwards -> no pulse.
- Client 5=50 with event (5,10) queued and `clr_valid`/`clr_client`=5 on the same edge -> entry 0 after that edge, then 10 after the next edge.
- `rd_client` toggles 1 -> 2 while client 2 drains +30 at the same edge -> output shows the post-write value for client 2 after that edge.
- Assert HRESETn low mid-stream with 3 queued events -> outputs 0 immediately. After release, all totals read 0 and no stale event drains.
